// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : vga_pkg                                                        |
// | Purpose : Shared geometry, framebuffer, colour and sprite constants for  |
// |           the VGA sprite compositor and its sub-blocks.                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package vga_pkg;

  // Visible raster size.
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Background framebuffer is 320x240, each texel doubled in both axes.
  localparam int FB_W  = 320;
  localparam int FB_AW = 17;

  // RGB444 packing inside a 12-bit colour word.
  localparam int COLOR_W = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 8;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 0;

  // Player-car sprite geometry (power-of-two sides).
  localparam int SPR_WIDTH       = 32;
  localparam int SPR_HEIGHT      = 32;
  localparam int SPR_WIDTH_LOG2  = $clog2(SPR_WIDTH);
  localparam int SPR_HEIGHT_LOG2 = $clog2(SPR_HEIGHT);

  // Colour keys.
  localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 12'hF0F;
  localparam logic [COLOR_W-1:0] OFFROAD_KEY     = 12'h0A0;

endpackage
`default_nettype wire

// File: rtl/sprite_locator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sprite_locator                                                 |
// | Purpose : Combinational sprite hit test and sprite ROM address for the   |
// |           current pixel; the parent registers both results.              |
// | Ports   : row_i/col_i      current raster position                       |
// |           pos_x_i/pos_y_i  sprite top-left corner                        |
// |           hit_o            pixel lies inside the sprite rectangle        |
// |           spr_addr_o       {row offset, column offset} into sprite ROM   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sprite_locator
  import vga_pkg::*;
#(
  parameter int SPR_W = SPR_WIDTH,
  parameter int SPR_H = SPR_HEIGHT
) (
  input  logic [9:0]                               row_i,
  input  logic [9:0]                               col_i,
  input  logic [9:0]                               pos_x_i,
  input  logic [9:0]                               pos_y_i,
  output logic                                     hit_o,
  output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0]   spr_addr_o
);

  localparam int AW_X = $clog2(SPR_W);
  localparam int AW_Y = $clog2(SPR_H);

  // One extra bit so pos + size never wraps: a sprite parked near 1023
  // must not reappear at the left/top edge.
  logic [10:0] col_ext, row_ext, px_ext, py_ext;
  logic [AW_X-1:0] dx;
  logic [AW_Y-1:0] dy;

  assign col_ext = {1'b0, col_i};
  assign row_ext = {1'b0, row_i};
  assign px_ext  = {1'b0, pos_x_i};
  assign py_ext  = {1'b0, pos_y_i};

  assign hit_o = (col_ext >= px_ext) && (col_ext < px_ext + 11'(SPR_W)) &&
                 (row_ext >= py_ext) && (row_ext < py_ext + 11'(SPR_H));

  // Low bits of a difference depend only on low bits of the operands.
  assign dx = col_i[AW_X-1:0] - pos_x_i[AW_X-1:0];
  assign dy = row_i[AW_Y-1:0] - pos_y_i[AW_Y-1:0];

  assign spr_addr_o = {dy, dx};

endmodule
`default_nettype wire

// File: rtl/vga_sprite_compositor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vga_sprite_compositor                                          |
// | Purpose : 3-stage pixel pipeline: fetches the doubled 320x240 background,|
// |           overlays the car sprite with a transparency key, outputs       |
// |           RGB444 with matching sync delay. Applies CPU position updates  |
// |           at frame boundaries; reports off-road collision per frame and  |
// |           a wrapping frame counter.                                      |
// | Ports   : clock, rst (async, active low)                                 |
// |           pixel_row/pixel_column/video_on/horiz_sync/vert_sync  timing   |
// |           pos_valid/pos_ready/pos_x/pos_y   CPU position handshake       |
// |           bg_addr/bg_data, spr_addr/spr_data  1-cycle-latency memories   |
// |           vga_r/g/b, vga_hs/vga_vs          VGA pins                     |
// |           collision, frame_count            status                       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int                 VERT_PIXELS   = V_ACTIVE,
  parameter int                 SPR_W         = SPR_WIDTH,
  parameter int                 SPR_H         = SPR_HEIGHT,
  parameter logic [COLOR_W-1:0] TRANSPARENT   = TRANSPARENT_KEY,
  parameter logic [COLOR_W-1:0] OFFROAD_COLOR = OFFROAD_KEY,
  parameter int                 START_X       = 304,
  parameter int                 START_Y       = 400
) (
  input  logic                                   clock,
  input  logic                                   rst,
  input  logic [9:0]                             pixel_row,
  input  logic [9:0]                             pixel_column,
  input  logic                                   video_on,
  input  logic                                   horiz_sync,
  input  logic                                   vert_sync,
  input  logic                                   pos_valid,
  output logic                                   pos_ready,
  input  logic [9:0]                             pos_x,
  input  logic [9:0]                             pos_y,
  output logic [FB_AW-1:0]                       bg_addr,
  input  logic [COLOR_W-1:0]                     bg_data,
  output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0] spr_addr,
  input  logic [COLOR_W-1:0]                     spr_data,
  output logic [CH_W-1:0]                        vga_r,
  output logic [CH_W-1:0]                        vga_g,
  output logic [CH_W-1:0]                        vga_b,
  output logic                                   vga_hs,
  output logic                                   vga_vs,
  output logic                                   collision,
  output logic [15:0]                            frame_count
);

  localparam int SPR_AW = $clog2(SPR_W) + $clog2(SPR_H);

  logic                boundary;
  logic                loc_hit;
  logic [SPR_AW-1:0]   loc_spr_addr;
  logic                spr_opaque;
  logic                coll_set;

  logic [FB_AW-1:0]    bg_addr_d, bg_addr_q;
  logic [SPR_AW-1:0]   spr_addr_q;
  logic [1:0]          hit_pipe_q, vid_pipe_q;
  logic [2:0]          hs_pipe_q, vs_pipe_q;
  logic [COLOR_W-1:0]  rgb_d, rgb_q;
  logic [9:0]          act_x_q, act_y_q, pend_x_q, pend_y_q;
  logic                sticky_d, sticky_q;
  logic                collision_q;
  logic [15:0]         frame_count_q;
  logic                ready_en_q;

  sprite_locator #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_sprite_locator (
    .row_i      (pixel_row),
    .col_i      (pixel_column),
    .pos_x_i    (act_x_q),
    .pos_y_i    (act_y_q),
    .hit_o      (loc_hit),
    .spr_addr_o (loc_spr_addr)
  );

  always_comb begin
    boundary  = (pixel_row == 10'(VERT_PIXELS)) && (pixel_column == 10'd0);

    // Address is clamped in blanking so the framebuffer never sees an
    // out-of-range index.
    bg_addr_d = '0;
    if (video_on) begin
      bg_addr_d = FB_AW'(pixel_row[9:1]) * FB_AW'(FB_W) + FB_AW'(pixel_column[9:1]);
    end

    spr_opaque = hit_pipe_q[1] && (spr_data != TRANSPARENT);

    rgb_d = '0;
    if (vid_pipe_q[1]) begin
      rgb_d = spr_opaque ? spr_data : bg_data;
    end

    coll_set = vid_pipe_q[1] && spr_opaque && (bg_data == OFFROAD_COLOR);
    // A hit landing on the boundary cycle belongs to the new frame.
    sticky_d = coll_set | (sticky_q & ~boundary);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      bg_addr_q     <= '0;
      spr_addr_q    <= '0;
      hit_pipe_q    <= '0;
      vid_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= '0;
      act_x_q       <= 10'(START_X);
      act_y_q       <= 10'(START_Y);
      pend_x_q      <= 10'(START_X);
      pend_y_q      <= 10'(START_Y);
      sticky_q      <= 1'b0;
      collision_q   <= 1'b0;
      frame_count_q <= '0;
      ready_en_q    <= 1'b0;
    end else begin
      bg_addr_q  <= bg_addr_d;
      spr_addr_q <= loc_spr_addr;
      hit_pipe_q <= {hit_pipe_q[0], loc_hit};
      vid_pipe_q <= {vid_pipe_q[0], video_on};
      hs_pipe_q  <= {hs_pipe_q[1:0], horiz_sync};
      vs_pipe_q  <= {vs_pipe_q[1:0], vert_sync};
      rgb_q      <= rgb_d;
      sticky_q   <= sticky_d;
      ready_en_q <= 1'b1;

      if (pos_valid && pos_ready) begin
        pend_x_q <= pos_x;
        pend_y_q <= pos_y;
      end

      if (boundary) begin
        act_x_q       <= pend_x_q;
        act_y_q       <= pend_y_q;
        collision_q   <= sticky_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  // Refusing writes on the boundary cycle keeps the pending->active copy
  // from racing a new CPU write.
  assign pos_ready   = ready_en_q & ~boundary;

  assign bg_addr     = bg_addr_q;
  assign spr_addr    = spr_addr_q;
  assign vga_r       = rgb_q[R_LSB+CH_W-1:R_LSB];
  assign vga_g       = rgb_q[G_LSB+CH_W-1:G_LSB];
  assign vga_b       = rgb_q[B_LSB+CH_W-1:B_LSB];
  assign vga_hs      = hs_pipe_q[2];
  assign vga_vs      = vs_pipe_q[2];
  assign collision   = collision_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_compositor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_vga_sprite_compositor                                       |
// | Purpose : Directed self-checking bench for vga_sprite_compositor.        |
// |           Memory data is driven from one cycle after the address is      |
// |           registered and held until the output stage captures it.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_vga_sprite_compositor;

  logic        clock = 1'b0;
  logic        rst;
  logic [9:0]  pixel_row, pixel_column;
  logic        video_on, horiz_sync, vert_sync;
  logic        pos_valid, pos_ready;
  logic [9:0]  pos_x, pos_y;
  logic [16:0] bg_addr;
  logic [11:0] bg_data;
  logic [9:0]  spr_addr;
  logic [11:0] spr_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, collision;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  vga_sprite_compositor dut (
    .clock        (clock),
    .rst          (rst),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .video_on     (video_on),
    .horiz_sync   (horiz_sync),
    .vert_sync    (vert_sync),
    .pos_valid    (pos_valid),
    .pos_ready    (pos_ready),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .bg_addr      (bg_addr),
    .bg_data      (bg_data),
    .spr_addr     (spr_addr),
    .spr_data     (spr_data),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .collision    (collision),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #2;
  endtask

  // One active pixel through the pipe; the following samples are blanking
  // at the same position so the address clamp is visible.
  task automatic pixel(input string tag, input logic [9:0] r, input logic [9:0] c,
                       input logic [11:0] bg, input logic [11:0] spr,
                       input logic [16:0] exp_bg, input logic [9:0] exp_spr,
                       input logic [11:0] exp_rgb);
    pixel_row = r; pixel_column = c; video_on = 1'b1;
    clk1();
    check({tag, "/bg_addr"}, 32'(bg_addr), 32'(exp_bg));
    check({tag, "/spr_addr"}, 32'(spr_addr), 32'(exp_spr));
    video_on = 1'b0; bg_data = bg; spr_data = spr;
    clk1();
    check({tag, "/bg_clamp"}, 32'(bg_addr), 32'd0);
    clk1();
    check({tag, "/rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
  endtask

  task automatic frame_boundary(input string tag);
    pixel_row = 10'd0; pixel_column = 10'd0; video_on = 1'b0;
    clk1();
    pixel_row = 10'd480; pixel_column = 10'd0;
    #1;
    check({tag, "/ready_at_boundary"}, 32'(pos_ready), 32'd0);
    clk1();
    pixel_row = 10'd0; pixel_column = 10'd0;
    #1;
    check({tag, "/ready_after"}, 32'(pos_ready), 32'd1);
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b0;
    pixel_row = 10'd0; pixel_column = 10'd0; video_on = 1'b1;
    horiz_sync = 1'b0; vert_sync = 1'b0;
    pos_valid = 1'b0; pos_x = 10'd0; pos_y = 10'd0;
    bg_data = 12'h5A7; spr_data = 12'hF0F;
    clk1();
    clk1();
    check("rst/rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst/hs", 32'(vga_hs), 32'd1);
    check("rst/vs", 32'(vga_vs), 32'd1);
    check("rst/bg_addr", 32'(bg_addr), 32'd0);
    check("rst/spr_addr", 32'(spr_addr), 32'd0);
    check("rst/collision", 32'(collision), 32'd0);
    check("rst/frame_count", 32'(frame_count), 32'd0);
    check("rst/pos_ready", 32'(pos_ready), 32'd0);

    // ---------------- release at row 0 col 0: 3-clock latency ----------------
    horiz_sync = 1'b1; vert_sync = 1'b1;
    rst = 1'b1;
    clk1();
    check("rel/rgb_c1", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rel/hs_c1", 32'(vga_hs), 32'd1);
    check("rel/vs_c1", 32'(vga_vs), 32'd1);
    check("rel/pos_ready", 32'(pos_ready), 32'd1);
    video_on = 1'b0; pixel_column = 10'd1;
    clk1();
    check("rel/rgb_c2", 32'({vga_r, vga_g, vga_b}), 32'd0);
    clk1();
    check("rel/rgb_c3", 32'({vga_r, vga_g, vga_b}), 32'h5A7);
    clk1();
    check("rel/rgb_c4", 32'({vga_r, vga_g, vga_b}), 32'd0);

    // ---------------- background fetch, reset sprite position (304,400) ------
    pixel("bg_10_21", 10'd10, 10'd21, 12'h123, 12'hABC, 17'd1610, 10'd837, 12'h123);

    // ---------------- sync delay ----------------
    pixel_row = 10'd0; pixel_column = 10'd700; video_on = 1'b0;
    horiz_sync = 1'b0; vert_sync = 1'b1;
    clk1();
    check("sync/hs_e1", 32'(vga_hs), 32'd1);
    horiz_sync = 1'b1; vert_sync = 1'b0;
    clk1();
    check("sync/hs_e2", 32'(vga_hs), 32'd1);
    check("sync/vs_e2", 32'(vga_vs), 32'd1);
    horiz_sync = 1'b1; vert_sync = 1'b1;
    clk1();
    check("sync/hs_e3", 32'(vga_hs), 32'd0);
    check("sync/vs_e3", 32'(vga_vs), 32'd1);
    clk1();
    check("sync/hs_e4", 32'(vga_hs), 32'd1);
    check("sync/vs_e4", 32'(vga_vs), 32'd0);

    // ---------------- mid-frame position write (100,50) ----------------
    pixel_row = 10'd20; pixel_column = 10'd5; video_on = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
    #1;
    check("pos/ready_mid", 32'(pos_ready), 32'd1);
    clk1();
    pos_valid = 1'b0;
    // Still the old position until the boundary.
    pixel("pre_bnd", 10'd50, 10'd100, 12'h123, 12'hABC, 17'd8050, 10'd84, 12'h123);
    frame_boundary("bnd1");
    check("bnd1/frame_count", 32'(frame_count), 32'd1);
    check("bnd1/collision", 32'(collision), 32'd0);

    // ---------------- sprite drawing at (100,50) ----------------
    pixel("spr_origin", 10'd50, 10'd100, 12'h123, 12'hABC, 17'd8050, 10'd0, 12'hABC);
    pixel("spr_transp", 10'd50, 10'd101, 12'h0A0, 12'hF0F, 17'd8050, 10'd1, 12'h0A0);
    pixel("spr_corner", 10'd81, 10'd131, 12'h456, 12'h5C3, 17'd12865, 10'd1023, 12'h5C3);
    pixel("spr_below", 10'd82, 10'd131, 12'h456, 12'h5C3, 17'd13185, 10'd31, 12'h456);
    pixel("spr_left", 10'd50, 10'd99, 12'h789, 12'hABC, 17'd8049, 10'd31, 12'h789);

    // ---------------- collision ----------------
    pixel("coll_hit", 10'd60, 10'd110, 12'h0A0, 12'hABC, 17'd9655, 10'd330, 12'hABC);
    check("coll/before_bnd", 32'(collision), 32'd0);
    frame_boundary("bnd2");
    check("bnd2/collision", 32'(collision), 32'd1);
    check("bnd2/frame_count", 32'(frame_count), 32'd2);
    frame_boundary("bnd3");
    check("bnd3/collision", 32'(collision), 32'd0);
    check("bnd3/frame_count", 32'(frame_count), 32'd3);

    // ---------------- sprite near 1023: no wrap ----------------
    pixel_row = 10'd100; pixel_column = 10'd3; video_on = 1'b0;
    pos_x = 10'd1020; pos_y = 10'd50; pos_valid = 1'b1;
    clk1();
    pos_valid = 1'b0;
    frame_boundary("bnd4");
    check("bnd4/frame_count", 32'(frame_count), 32'd4);
    pixel("far_c639", 10'd50, 10'd639, 12'h123, 12'hABC, 17'd8319, 10'd3, 12'h123);
    pixel("far_c2", 10'd50, 10'd2, 12'h123, 12'hABC, 17'd8001, 10'd6, 12'h123);

    // ---------------- frame counter wrap ----------------
    // Holding the boundary coordinates counts one frame per clock.
    pixel_row = 10'd480; pixel_column = 10'd0; video_on = 1'b0;
    for (int i = 0; i < 65531; i++) clk1();
    check("wrap/ffff", 32'(frame_count), 32'hFFFF);
    clk1();
    check("wrap/zero", 32'(frame_count), 32'd0);
    pixel_row = 10'd0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
